// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types for the ALU board front end: the ALU function selector used by `top`
// and the operand sequencer's state encoding.
package definitions_pkg;

  typedef enum logic [3:0] {
    FN_ADD    = 4'd0,
    FN_SUB    = 4'd1,
    FN_AND    = 4'd2,
    FN_OR     = 4'd3,
    FN_XOR    = 4'd4,
    FN_NOR    = 4'd5,
    FN_SLL    = 4'd6,
    FN_SRL    = 4'd7,
    FN_SRA    = 4'd8,
    FN_PASS_A = 4'd9
  } test_selector_t;

  localparam int FUNC_W    = $bits(test_selector_t);
  // Must track the member count of test_selector_t above.
  localparam int NUM_FUNCS = 10;

  typedef enum logic [2:0] {
    ST_LOAD_A = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_LOAD_F = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SHOW   = 3'd4
  } seq_state_t;

  function automatic logic func_legal(input logic [FUNC_W-1:0] code);
    return code < FUNC_W'(NUM_FUNCS);
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_edge_pulse.sv
// Rising-edge detector: registers a level input and emits a one-cycle pulse
// in the cycle the level first goes high.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse
);

  logic r_level_q;

  always_ff @(posedge clk) begin
    if (reset) r_level_q <= 1'b0;
    else       r_level_q <= i_level;
  end

  assign o_pulse = i_level & ~r_level_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Switch/button front end for the ALU: collects A, B and a function code on enter
// presses, drives `top` with a stable operand pair, then captures LED after settling.
module alu_operand_sequencer
  import definitions_pkg::*;
#(
  parameter int BITS          = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BITS-1:0]  sw,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output test_selector_t   alu_func,
  output logic [BITS-1:0]  alu_sw,
  input  logic [BITS-1:0]  alu_led,
  output logic [BITS-1:0]  result,
  output logic             result_valid,
  output logic             func_err,
  output logic [2:0]       state_code,
  output logic [CNT_W-1:0] op_count
);

  localparam int HALF = BITS / 2;
  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_t        r_state;
  logic [HALF-1:0]   r_a;
  logic [HALF-1:0]   r_b;
  test_selector_t    r_alu_func;
  logic [BITS-1:0]   r_alu_sw;
  logic [BITS-1:0]   r_result;
  logic              r_result_valid;
  logic              r_func_err;
  logic [CNT_W-1:0]  r_op_count;
  logic [SC_W-1:0]   r_settle_cnt;

  logic              w_enter_pulse;
  logic [FUNC_W-1:0] w_code;
  logic              w_unused_sw_hi;

  // B is keyed in on the low switches too, so the upper half is never read.
  assign w_code         = sw[FUNC_W-1:0];
  assign w_unused_sw_hi = ^sw[BITS-1:HALF];

  edge_pulse u_enter_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (btn_enter),
    .o_pulse (w_enter_pulse)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_LOAD_A;
      r_a            <= '0;
      r_b            <= '0;
      r_alu_func     <= test_selector_t'(0);
      r_alu_sw       <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_func_err     <= 1'b0;
      r_op_count     <= '0;
      r_settle_cnt   <= '0;
    end else begin
      r_func_err <= 1'b0;
      if (btn_clear) begin
        // Abandons any operation in flight; the ALU keeps its last operands.
        r_state        <= ST_LOAD_A;
        r_a            <= '0;
        r_b            <= '0;
        r_result_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_LOAD_A: begin
            if (w_enter_pulse) begin
              r_a     <= sw[HALF-1:0];
              r_state <= ST_LOAD_B;
            end
          end
          ST_LOAD_B: begin
            if (w_enter_pulse) begin
              r_b     <= sw[HALF-1:0];
              r_state <= ST_LOAD_F;
            end
          end
          ST_LOAD_F: begin
            if (w_enter_pulse) begin
              if (func_legal(w_code)) begin
                r_alu_func   <= test_selector_t'(w_code);
                r_alu_sw     <= {r_b, r_a};
                r_settle_cnt <= SC_W'(SETTLE_CYCLES - 1);
                r_state      <= ST_EXEC;
              end else begin
                r_func_err <= 1'b1;
              end
            end
          end
          ST_EXEC: begin
            if (r_settle_cnt == '0) begin
              r_result       <= alu_led;
              r_result_valid <= 1'b1;
              r_op_count     <= r_op_count + CNT_W'(1);
              r_state        <= ST_SHOW;
            end else begin
              r_settle_cnt <= r_settle_cnt - SC_W'(1);
            end
          end
          ST_SHOW: begin
            if (w_enter_pulse) r_state <= ST_LOAD_A;
          end
          default: r_state <= ST_LOAD_A;
        endcase
      end
    end
  end

  assign alu_func     = r_alu_func;
  assign alu_sw       = r_alu_sw;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign func_err     = r_func_err;
  assign state_code   = r_state;
  assign op_count     = r_op_count;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural ALU on alu_led and a
// queue of expected results pushed at function entry and popped at capture.
module tb_alu_operand_sequencer;
  import definitions_pkg::*;

  localparam int BITS  = 16;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [BITS-1:0]  sw;
  logic             btn_enter;
  logic             btn_clear;
  test_selector_t   alu_func;
  logic [BITS-1:0]  alu_sw;
  logic [BITS-1:0]  alu_led;
  logic [BITS-1:0]  result;
  logic             result_valid;
  logic             func_err;
  logic [2:0]       state_code;
  logic [CNT_W-1:0] op_count;

  int               checks = 0;
  int               errors = 0;
  logic [15:0]      exp_q[$];
  logic [CNT_W-1:0] exp_cnt;
  logic [15:0]      last_result;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.BITS(BITS), .SETTLE_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .sw           (sw),
    .btn_enter    (btn_enter),
    .btn_clear    (btn_clear),
    .alu_func     (alu_func),
    .alu_sw       (alu_sw),
    .alu_led      (alu_led),
    .result       (result),
    .result_valid (result_valid),
    .func_err     (func_err),
    .state_code   (state_code),
    .op_count     (op_count)
  );

  function automatic logic [15:0] alu_model(input logic [3:0] f, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [15:0] wa;
    logic [15:0] wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (f)
      4'd0:    return wa + wb;
      4'd1:    return wa - wb;
      4'd2:    return wa & wb;
      4'd3:    return wa | wb;
      4'd4:    return wa ^ wb;
      4'd5:    return {8'h00, ~(a | b)};
      4'd6:    return wa << b[2:0];
      4'd7:    return wa >> b[2:0];
      4'd8:    return {8'h00, 8'($signed(a) >>> b[2:0])};
      4'd9:    return wa;
      default: return 16'hDEAD;
    endcase
  endfunction

  assign alu_led = alu_model(alu_func, alu_sw[7:0], alu_sw[15:8]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One released cycle first so every press is seen as a fresh rising edge.
  task automatic press(input logic [15:0] v);
    tick();
    sw        = v;
    btn_enter = 1'b1;
    tick();
    btn_enter = 1'b0;
  endtask

  // Called right after the edge that accepted a legal function code.
  task automatic exec_check(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    logic [15:0] e;
    exp_q.push_back(alu_model(f, a, b));
    chk("exec_entry_state", 32'(state_code), 32'd3);
    chk("exec_alu_sw", 32'(alu_sw), 32'({b, a}));
    chk("exec_alu_func", 32'(alu_func), 32'(f));
    tick();
    chk("exec_settle_state", 32'(state_code), 32'd3);
    tick();
    chk("capture_state", 32'(state_code), 32'd4);
    e = exp_q.pop_front();
    chk("capture_result", 32'(result), 32'(e));
    chk("capture_valid", 32'(result_valid), 32'd1);
    exp_cnt = exp_cnt + 2'd1;
    chk("capture_op_count", 32'(op_count), 32'(exp_cnt));
    last_result = e;
    $display("op a=%02h b=%02h f=%0d result=%04h expected=%04h count=%0d",
             a, b, f, result, e, op_count);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    if (state_code == 3'd4) press(16'h0000);
    press({8'h00, a});
    press({8'h00, b});
    press({12'h000, f});
    exec_check(a, b, f);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state_code), 32'd0);
    chk({tag, "_alu_sw"}, 32'(alu_sw), 32'd0);
    chk({tag, "_alu_func"}, 32'(alu_func), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_func_err"}, 32'(func_err), 32'd0);
    chk({tag, "_op_count"}, 32'(op_count), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    sw          = '0;
    btn_enter   = 1'b0;
    btn_clear   = 1'b0;
    exp_cnt     = '0;
    last_result = '0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("reset");

    // Basic operation.
    run_op(8'h12, 8'h34, 4'd0);

    // Held enter button advances exactly one state.
    press(16'h0000);
    chk("show_to_load_a", 32'(state_code), 32'd0);
    tick();
    sw        = 16'h0056;
    btn_enter = 1'b1;
    repeat (20) tick();
    btn_enter = 1'b0;
    chk("held_button_state", 32'(state_code), 32'd1);
    $display("held enter 20 cycles state=%0d", state_code);

    // Illegal function code, then a legal one.
    press(16'h0007);
    chk("load_b_to_f", 32'(state_code), 32'd2);
    press(16'(NUM_FUNCS));
    chk("illegal_func_err", 32'(func_err), 32'd1);
    chk("illegal_state", 32'(state_code), 32'd2);
    chk("illegal_alu_func", 32'(alu_func), 32'd0);
    tick();
    chk("illegal_func_err_drop", 32'(func_err), 32'd0);
    chk("illegal_state_hold", 32'(state_code), 32'd2);
    $display("illegal code %0d rejected state=%0d", NUM_FUNCS, state_code);
    press(16'h0006);
    exec_check(8'h56, 8'h07, 4'd6);

    // Clear in the first EXEC cycle.
    press(16'h0000);
    press(16'h009A);
    press(16'h00BC);
    press(16'h0001);
    chk("clr_exec_state", 32'(state_code), 32'd3);
    chk("clr_exec_alu_sw", 32'(alu_sw), 32'hBC9A);
    btn_clear = 1'b1;
    tick();
    btn_clear = 1'b0;
    chk("clr_state", 32'(state_code), 32'd0);
    chk("clr_valid", 32'(result_valid), 32'd0);
    chk("clr_op_count", 32'(op_count), 32'(exp_cnt));
    chk("clr_result_kept", 32'(result), 32'(last_result));
    chk("clr_alu_sw_kept", 32'(alu_sw), 32'hBC9A);
    tick();
    tick();
    chk("clr_no_capture_count", 32'(op_count), 32'(exp_cnt));
    chk("clr_no_capture_state", 32'(state_code), 32'd0);
    $display("clear in EXEC state=%0d count=%0d", state_code, op_count);

    // Counter wrap from a fresh reset: 1,2,3,0,1.
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    exp_cnt     = '0;
    last_result = '0;
    chk("wrap_start_count", 32'(op_count), 32'd0);
    run_op(8'hF0, 8'h0F, 4'd3);
    run_op(8'h80, 8'h03, 4'd8);
    run_op(8'hFF, 8'h01, 4'd0);
    run_op(8'h05, 8'h09, 4'd1);
    run_op(8'hAA, 8'h55, 4'd4);

    // Reset while in SHOW.
    chk("pre_reset_show", 32'(state_code), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("show_reset");
    $display("reset in SHOW state=%0d count=%0d", state_code, op_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
